// File: rtl/rv32_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_bus_pkg
// Brief    : Shared encodings for the RV32I fetch/LSU memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rv32_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_I = 2'd1,
        ST_WAIT_D = 2'd2
    } arb_state_t;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    // Fetches always read a full word; replicate this bit across the byte-enable width.
    localparam logic IF_BE_BIT = 1'b1;

    function automatic logic owner_of_state(input arb_state_t s);
        return (s == ST_WAIT_D) ? OWN_LSU : OWN_IF;
    endfunction

endpackage : rv32_bus_pkg
`default_nettype wire

// File: rtl/rv32_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : rv32_arb_watchdog
// Brief    : Response-wait counter; expire flags the last allowed wait cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_arb_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = enable && (cnt == CNT_LAST);

endmodule : rv32_arb_watchdog
`default_nettype wire

// File: rtl/rv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv32_mem_arbiter
// Brief    : One-outstanding-transaction arbiter between IF and LSU masters
//            and a single-port memory, with a response watchdog.
//            Define RV32_ARB_RR_EN for round-robin conflict resolution.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_mem_arbiter
    import rv32_bus_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                err,
    output logic                err_src
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t state;
    arb_state_t state_nxt;
    logic       grant;
    logic       sel_lsu;
    logic       in_wait;
    logic       owner;
    logic       resp;
    logic       tout;
    logic       expire;

    // Gating with rst keeps grants quiet while reset is held, not just after the edge.
    assign grant   = !rst && (state == ST_IDLE) && (if_req || d_req);
    assign in_wait = (state == ST_WAIT_I) || (state == ST_WAIT_D);
    assign owner   = owner_of_state(state);
    assign resp    = in_wait && mem_rvalid;
    assign tout    = in_wait && expire && !mem_rvalid;

`ifdef RV32_ARB_RR_EN
    logic last_owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= OWN_IF;
        end else if (grant) begin
            last_owner <= sel_lsu ? OWN_LSU : OWN_IF;
        end
    end

    // On conflict the master that did not own the previous transaction wins.
    assign sel_lsu = d_req && (!if_req || (last_owner == OWN_IF));
`else
    assign sel_lsu = d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        err       = 1'b0;
        err_src   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (grant) begin
                    mem_req = 1'b1;
                    if (sel_lsu) begin
                        d_gnt     = 1'b1;
                        mem_we    = d_we;
                        mem_be    = d_be;
                        mem_addr  = d_addr;
                        mem_wdata = d_wdata;
                        state_nxt = ST_WAIT_D;
                    end else begin
                        if_gnt    = 1'b1;
                        mem_be    = {BE_W{IF_BE_BIT}};
                        mem_addr  = if_addr;
                        state_nxt = ST_WAIT_I;
                    end
                end
            end
            ST_WAIT_I, ST_WAIT_D: begin
                // A timeout completes the transaction with zero data so the owner never stalls.
                if (resp || tout) begin
                    state_nxt = ST_IDLE;
                    if (owner == OWN_LSU) begin
                        d_rvalid = 1'b1;
                        d_rdata  = resp ? mem_rdata : '0;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = resp ? mem_rdata : '0;
                    end
                end
                if (tout) begin
                    err     = 1'b1;
                    err_src = owner;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    rv32_arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (grant),
        .enable (in_wait),
        .expire (expire)
    );

endmodule : rv32_mem_arbiter
`default_nettype wire

// File: tb/tb_rv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_mem_arbiter
// Brief    : Directed, table-driven bench for rv32_mem_arbiter (TIMEOUT_CYC=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err, err_src;

    always #5 clk = ~clk;

    rv32_mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_be       (d_be),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .err        (err),
        .err_src    (err_src)
    );

    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [3:0]  d_be;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        mem_rvalid;
        logic [31:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic        if_gnt;
        logic        d_gnt;
        logic        mem_req;
        logic        mem_we;
        logic [3:0]  mem_be;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        d_rvalid;
        logic [31:0] d_rdata;
        logic        err;
        logic        err_src;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t cur;
    vec_t tbl[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic out_t sample();
        out_t s;
        s.if_gnt    = if_gnt;
        s.d_gnt     = d_gnt;
        s.mem_req   = mem_req;
        s.mem_we    = mem_we;
        s.mem_be    = mem_be;
        s.mem_addr  = mem_addr;
        s.mem_wdata = mem_wdata;
        s.if_rvalid = if_rvalid;
        s.if_rdata  = if_rdata;
        s.d_rvalid  = d_rvalid;
        s.d_rdata   = d_rdata;
        s.err       = err;
        s.err_src   = err_src;
        return s;
    endfunction

    task automatic drive(input in_t v);
        if_req     = v.if_req;
        if_addr    = v.if_addr;
        d_req      = v.d_req;
        d_we       = v.d_we;
        d_be       = v.d_be;
        d_addr     = v.d_addr;
        d_wdata    = v.d_wdata;
        mem_rvalid = v.mem_rvalid;
        mem_rdata  = v.mem_rdata;
    endtask

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = sample();
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Vector builders: s* set stimulus, g*/r* set expected grant/response.
    task automatic si(input logic [31:0] a);
        cur.i.if_req  = 1'b1;
        cur.i.if_addr = a;
    endtask
    task automatic sd(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
        cur.i.d_req   = 1'b1;
        cur.i.d_we    = we;
        cur.i.d_be    = be;
        cur.i.d_addr  = a;
        cur.i.d_wdata = wd;
    endtask
    task automatic sr(input logic [31:0] dat);
        cur.i.mem_rvalid = 1'b1;
        cur.i.mem_rdata  = dat;
    endtask
    task automatic gi(input logic [31:0] a);
        cur.o.if_gnt   = 1'b1;
        cur.o.mem_req  = 1'b1;
        cur.o.mem_be   = 4'hF;
        cur.o.mem_addr = a;
    endtask
    task automatic gd(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
        cur.o.d_gnt     = 1'b1;
        cur.o.mem_req   = 1'b1;
        cur.o.mem_we    = we;
        cur.o.mem_be    = be;
        cur.o.mem_addr  = a;
        cur.o.mem_wdata = wd;
    endtask
    task automatic ri(input logic [31:0] dat);
        cur.o.if_rvalid = 1'b1;
        cur.o.if_rdata  = dat;
    endtask
    task automatic rd(input logic [31:0] dat);
        cur.o.d_rvalid = 1'b1;
        cur.o.d_rdata  = dat;
    endtask
    task automatic push();
        tbl.push_back(cur);
        cur = '0;
    endtask

    task automatic run_timeout(input logic lsu);
        in_t  v;
        out_t e;
        @(posedge clk); #1;
        v = '0;
        e = '0;
        e.mem_req = 1'b1;
        e.mem_be  = 4'hF;
        if (lsu) begin
            v.d_req = 1'b1; v.d_be = 4'hF; v.d_addr = 32'h500;
            e.d_gnt = 1'b1; e.mem_addr = 32'h500;
        end else begin
            v.if_req = 1'b1; v.if_addr = 32'h400;
            e.if_gnt = 1'b1; e.mem_addr = 32'h400;
        end
        drive(v);
        @(negedge clk);
        check($sformatf("timeout_%s_grant", lsu ? "d" : "i"), e);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            v = '0;
            v.mem_rvalid = (k == 10);
            v.mem_rdata  = 32'hBAD0_0000;
            drive(v);
            e = '0;
            if (k == 8) begin
                e.err     = 1'b1;
                e.err_src = lsu;
                if (lsu) e.d_rvalid = 1'b1;
                else     e.if_rvalid = 1'b1;
            end
            @(negedge clk);
            check($sformatf("timeout_%s_cyc%0d", lsu ? "d" : "i", k), e);
        end
    endtask

    task automatic run_reset_abort();
        in_t  v;
        out_t e;
        @(posedge clk); #1;
        v = '0;
        v.d_req = 1'b1; v.d_we = 1'b1; v.d_be = 4'hC; v.d_addr = 32'h700; v.d_wdata = 32'h1111_2222;
        drive(v);
        e = '0;
        e.d_gnt = 1'b1; e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_be = 4'hC;
        e.mem_addr = 32'h700; e.mem_wdata = 32'h1111_2222;
        @(negedge clk);
        check("rst_abort_grant", e);
        @(posedge clk); #1;
        v = '0;
        v.if_req = 1'b1; v.if_addr = 32'h600;
        v.mem_rvalid = 1'b1; v.mem_rdata = 32'hCAFE_F00D;
        drive(v);
        #1;
        e = '0; e.d_rvalid = 1'b1; e.d_rdata = 32'hCAFE_F00D;
        check("rst_abort_pre_rvalid", e);
        #1 rst = 1'b1;
        #1 check("rst_abort_async_zero", '0);
        @(negedge clk);
        v.mem_rvalid = 1'b0;
        drive(v);
        rst = 1'b0;
        #1;
        e = '0; e.if_gnt = 1'b1; e.mem_req = 1'b1; e.mem_be = 4'hF; e.mem_addr = 32'h600;
        check("rst_abort_first_gnt", e);
        @(posedge clk); #1;
        drive('0);
        @(negedge clk);
        check("rst_abort_wait_quiet", '0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b1;
        drive('0);
        cur = '0;

        // Single IF read, answered 3 cycles after grant
        si(32'h10); gi(32'h10); push();
        push();
        push();
        sr(32'h13); ri(32'h13); push();
        push();
        // Conflict round 1: LSU wins in both builds
        si(32'h20); sd(1'b0, 4'hF, 32'h100, 32'h0); gd(1'b0, 4'hF, 32'h100, 32'h0); push();
        si(32'h20); push();
        si(32'h20); sr(32'hDEAD_BEEF); rd(32'hDEAD_BEEF); push();
        // Conflict round 2
        si(32'h20); sd(1'b0, 4'hF, 32'h104, 32'h0);
`ifdef RV32_ARB_RR_EN
        gi(32'h20);
`else
        gd(1'b0, 4'hF, 32'h104, 32'h0);
`endif
        push();
        si(32'h20); sd(1'b0, 4'hF, 32'h104, 32'h0); push();
        si(32'h20); sd(1'b0, 4'hF, 32'h104, 32'h0); sr(32'h55);
`ifdef RV32_ARB_RR_EN
        ri(32'h55);
`else
        rd(32'h55);
`endif
        push();
        // Conflict round 3: LSU in both builds
        si(32'h20); sd(1'b0, 4'hF, 32'h104, 32'h0); gd(1'b0, 4'hF, 32'h104, 32'h0); push();
        si(32'h20); push();
        si(32'h20); sr(32'h66); rd(32'h66); push();
        si(32'h20); gi(32'h20); push();
        push();
        sr(32'h77); ri(32'h77); push();
        // LSU partial write; IF request during WAIT_D must wait
        sd(1'b1, 4'b0011, 32'h200, 32'hA5A5_1234); gd(1'b1, 4'b0011, 32'h200, 32'hA5A5_1234); push();
        si(32'h300); push();
        si(32'h300); sr(32'h0); rd(32'h0); push();
        si(32'h300); gi(32'h300); push();
        push();
        sr(32'h88); ri(32'h88); push();
        // Stray response in IDLE is ignored
        sr(32'h99); push();

        #12;
        check("reset_outputs_zero", '0);
        if_req = 1'b1;
        d_req  = 1'b1;
        #1 check("reset_blocks_grant", '0);
        drive('0);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < tbl.size(); n++) begin
            @(posedge clk); #1;
            drive(tbl[n].i);
            @(negedge clk);
            check($sformatf("vec%0d", n), tbl[n].o);
        end

        run_timeout(1'b0);
        run_timeout(1'b1);
        run_reset_abort();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_rv32_mem_arbiter
`default_nettype wire
